// File: rtl/nn_pkg.sv
// Shared constants, width helper and FSM state encoding
// for the neuron feeder datapath.
package nn_pkg;

  localparam int IN_WIDTH    = 4;
  localparam int NUM_INPUTS  = 784;
  localparam int NUM_NEURONS = 10;

  // Address width that never collapses to zero bits.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ACT_AW = cw(NUM_INPUTS);
  localparam int W_AW   = cw(NUM_INPUTS * NUM_NEURONS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_WAIT_RES,
    S_FIN
  } state_t;

endpackage

// File: rtl/act_buffer.sv
// Single-port activation store: written while idle,
// read with one cycle latency while streaming.
module act_buffer #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 784,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Synchronous write and registered read on the shared port.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/layer_feeder.sv
// Streams one layer's activations and weights through a single
// time-multiplexed neuron and reports each neuron's result.
module layer_feeder #(
  parameter int IN_WIDTH    = nn_pkg::IN_WIDTH,
  parameter int NUM_INPUTS  = nn_pkg::NUM_INPUTS,
  parameter int NUM_NEURONS = nn_pkg::NUM_NEURONS,
  parameter int ACT_AW      = nn_pkg::cw(NUM_INPUTS),
  parameter int W_AW        = nn_pkg::cw(NUM_INPUTS * NUM_NEURONS),
  parameter int IDX_W       = nn_pkg::cw(NUM_NEURONS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                act_wr_en,
  input  logic [ACT_AW-1:0]   act_wr_addr,
  input  logic [IN_WIDTH-1:0] act_wr_data,
  input  logic                start,
  input  logic                hold,
  output logic [W_AW-1:0]     w_rd_addr,
  input  logic [IN_WIDTH-1:0] w_rd_data,
  output logic [IN_WIDTH-1:0] nrn_data,
  output logic [IN_WIDTH-1:0] nrn_weight,
  output logic                nrn_valid,
  input  logic [3:0]          nrn_out,
  input  logic                nrn_out_vld,
  output logic                res_valid,
  output logic [IDX_W-1:0]    res_idx,
  output logic [3:0]          res_data,
  output logic                busy,
  output logic                done
);

  import nn_pkg::*;

  localparam int CW = cw(NUM_INPUTS + 1);
  localparam logic [CW-1:0]    I_LAST = CW'(NUM_INPUTS - 1);
  localparam logic [IDX_W-1:0] N_LAST = IDX_W'(NUM_NEURONS - 1);
  localparam logic [W_AW-1:0]  W_STEP = W_AW'(NUM_INPUTS);

  state_t              state;
  state_t              state_nxt;
  logic [CW-1:0]       i;
  logic [IDX_W-1:0]    n;
  logic [W_AW-1:0]     wbase;
  logic                issue;
  logic                res_take;
  logic                dv;
  logic                buf_we;
  logic [ACT_AW-1:0]   buf_addr;
  logic [IN_WIDTH-1:0] act_q;

  // Port is owned by the loader in IDLE, by the issue counter otherwise.
  assign buf_we   = act_wr_en && (state == S_IDLE);
  assign buf_addr = (state == S_IDLE) ? act_wr_addr : i[ACT_AW-1:0];

  act_buffer #(
    .WIDTH (IN_WIDTH),
    .DEPTH (NUM_INPUTS),
    .AW    (ACT_AW)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .addr  (buf_addr),
    .wdata (act_wr_data),
    .rdata (act_q)
  );

  // Next-state, beat issue and result acceptance.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    res_take  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_nxt = S_STREAM;
      end
      S_STREAM: begin
        if (!hold) begin
          issue = 1'b1;
          if (i == I_LAST) state_nxt = S_WAIT_RES;
        end
      end
      S_WAIT_RES: begin
        if (nrn_out_vld) begin
          res_take  = 1'b1;
          state_nxt = (n == N_LAST) ? S_FIN : S_STREAM;
        end
      end
      S_FIN: begin
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Beat, neuron and weight-base counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      i     <= '0;
      n     <= '0;
      wbase <= '0;
    end else begin
      if (issue) i <= i + 1'b1;
      if (res_take) begin
        i     <= '0;
        n     <= n + 1'b1;
        wbase <= wbase + W_STEP;
      end
      if (state == S_FIN) begin
        n     <= '0;
        wbase <= '0;
      end
    end
  end

  // Data stage: beat valid one cycle after its issue.
  always_ff @(posedge clk) begin
    if (rst) dv <= 1'b0;
    else     dv <= issue;
  end

  // Result capture from the neuron.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_idx   <= '0;
      res_data  <= '0;
    end else begin
      res_valid <= res_take;
      if (res_take) begin
        res_idx  <= n;
        res_data <= nrn_out;
      end
    end
  end

  assign w_rd_addr  = wbase + W_AW'(i);
  assign nrn_valid  = dv;
  assign nrn_data   = dv ? act_q : '0;
  assign nrn_weight = dv ? w_rd_data : '0;
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_FIN);

endmodule

// File: tb/tb_layer_feeder.sv
// Directed + random checks of layer_feeder with a stub neuron
// and a one-cycle weight ROM.
module tb_layer_feeder;

  localparam int N  = 4;
  localparam int NN = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       act_wr_en = 1'b0;
  logic [1:0] act_wr_addr = '0;
  logic [3:0] act_wr_data = '0;
  logic       start = 1'b0;
  logic       hold = 1'b0;
  logic [2:0] w_rd_addr;
  logic [3:0] w_rd_data = '0;
  logic [3:0] nrn_data;
  logic [3:0] nrn_weight;
  logic       nrn_valid;
  logic [3:0] nrn_out = '0;
  logic       nrn_out_vld = 1'b0;
  logic       res_valid;
  logic [0:0] res_idx;
  logic [3:0] res_data;
  logic       busy;
  logic       done;

  layer_feeder #(
    .IN_WIDTH    (4),
    .NUM_INPUTS  (N),
    .NUM_NEURONS (NN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .act_wr_en   (act_wr_en),
    .act_wr_addr (act_wr_addr),
    .act_wr_data (act_wr_data),
    .start       (start),
    .hold        (hold),
    .w_rd_addr   (w_rd_addr),
    .w_rd_data   (w_rd_data),
    .nrn_data    (nrn_data),
    .nrn_weight  (nrn_weight),
    .nrn_valid   (nrn_valid),
    .nrn_out     (nrn_out),
    .nrn_out_vld (nrn_out_vld),
    .res_valid   (res_valid),
    .res_idx     (res_idx),
    .res_data    (res_data),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int act_ref [N];
  int wts [8];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic spur = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) w_rd_data <= 4'(wts[w_rd_addr]);

  function automatic int sat_relu(input int s);
    if (s < 0) return 0;
    if ((s >>> 6) > 15) return 15;
    return s >>> 6;
  endfunction

  function automatic int ref_res(input int n);
    int s;
    s = 0;
    for (int k = 0; k < N; k++) s += act_ref[k] * wts[n*N+k];
    return sat_relu(s);
  endfunction

  // Stub neuron: MAC over N beats, result one cycle after the last.
  int acc = 0;
  int cnt = 0;
  always @(posedge clk) begin
    if (rst) begin
      acc <= 0; cnt <= 0;
      nrn_out_vld <= 1'b0; nrn_out <= '0;
    end else begin
      nrn_out_vld <= spur;
      if (nrn_valid) begin
        if (cnt == N-1) begin
          nrn_out_vld <= 1'b1;
          nrn_out <= 4'(sat_relu(acc + int'(nrn_data) * int'($signed(nrn_weight))));
          acc <= 0; cnt <= 0;
        end else begin
          acc <= acc + int'(nrn_data) * int'($signed(nrn_weight));
          cnt <= cnt + 1;
        end
      end
    end
  end

  // Monitor: record beats, results and done pulses.
  int b_addr [$];
  int b_data [$];
  int b_w [$];
  int r_idx [$];
  int r_data [$];
  int r_cyc [$];
  int done_cnt = 0;
  int done_res = 0;
  int first_v = -1;
  int prev_addr = 0;
  always @(negedge clk) begin
    if (nrn_valid) begin
      b_addr.push_back(prev_addr);
      b_data.push_back(int'(nrn_data));
      b_w.push_back(int'(nrn_weight));
      if (first_v < 0) first_v = cyc;
    end
    if (res_valid) begin
      r_idx.push_back(int'(res_idx));
      r_data.push_back(int'(res_data));
      r_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_res = r_idx.size();
    end
    prev_addr = int'(w_rd_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    b_addr.delete(); b_data.delete(); b_w.delete();
    r_idx.delete(); r_data.delete(); r_cyc.delete();
    done_cnt = 0; done_res = 0; first_v = -1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_outs(input string tag);
    chk({tag, "/busy"}, busy, 0);
    chk({tag, "/done"}, done, 0);
    chk({tag, "/nrn_valid"}, nrn_valid, 0);
    chk({tag, "/res_valid"}, res_valid, 0);
    chk({tag, "/w_rd_addr"}, w_rd_addr, 0);
    chk({tag, "/nrn_data"}, nrn_data, 0);
    chk({tag, "/nrn_weight"}, nrn_weight, 0);
    chk({tag, "/res_idx"}, res_idx, 0);
    chk({tag, "/res_data"}, res_data, 0);
  endtask

  task automatic load();
    for (int k = 0; k < N; k++) begin
      act_wr_en = 1'b1;
      act_wr_addr = 2'(k);
      act_wr_data = 4'(act_ref[k]);
      tick();
    end
    act_wr_en = 1'b0;
  endtask

  task automatic run(input string tag, input int hold_at,
                     input bit poke, input bit spur_on);
    int s;
    logic [3:0] ew;
    clr();
    start = 1'b1;
    s = cyc;
    tick();
    start = 1'b0;
    chk({tag, "/busy_after_start"}, busy, 1);
    for (int k = 0; k < 100; k++) begin
      hold = (hold_at >= 0) && (cyc >= s + hold_at) && (cyc < s + hold_at + 3);
      start = poke && (cyc == s + 3);
      act_wr_en = poke && (cyc == s + 3);
      act_wr_addr = '0;
      act_wr_data = 4'(act_ref[0] ^ 15);
      spur = spur_on && (cyc == s + 2);
      tick();
      if (done_cnt != 0) break;
    end
    hold = 1'b0; start = 1'b0; act_wr_en = 1'b0; spur = 1'b0;
    repeat (3) tick();
    chk({tag, "/done_pulses"}, done_cnt, 1);
    chk({tag, "/res_before_done"}, done_res, NN);
    chk({tag, "/busy_end"}, busy, 0);
    chk({tag, "/n_results"}, r_idx.size(), NN);
    for (int k = 0; k < NN && k < r_idx.size(); k++) begin
      chk({tag, "/res_idx"}, r_idx[k], k);
      chk({tag, "/res_data"}, r_data[k], ref_res(k));
    end
    chk({tag, "/n_beats"}, b_addr.size(), N*NN);
    for (int k = 0; k < N*NN && k < b_addr.size(); k++) begin
      ew = 4'(wts[k]);
      chk({tag, "/beat_addr"}, b_addr[k], k);
      chk({tag, "/beat_act"}, b_data[k], act_ref[k % N]);
      chk({tag, "/beat_w"}, b_w[k], ew);
    end
    if (hold_at < 0) begin
      chk({tag, "/lat_first_valid"}, first_v - s, 2);
      if (r_cyc.size() > 0) chk({tag, "/lat_first_res"}, r_cyc[0] - s, N + 3);
    end
  endtask

  task automatic rand_data();
    for (int k = 0; k < N; k++) act_ref[k] = int'($urandom_range(0, 15));
    for (int k = 0; k < 8; k++) wts[k] = int'($urandom_range(0, 15)) - 8;
  endtask

  initial begin
    int s;
    for (int k = 0; k < 8; k++) wts[k] = 0;
    for (int k = 0; k < N; k++) act_ref[k] = 0;
    repeat (3) tick();
    idle_outs("reset_in");
    rst = 1'b0;
    tick();
    idle_outs("reset_out");

    // All 15 x 7: each neuron 420 >> 6 = 6.
    for (int k = 0; k < N; k++) act_ref[k] = 15;
    for (int k = 0; k < 8; k++) wts[k] = 7;
    load();
    run("w7", -1, 1'b0, 1'b0);
    chk("w7/r0_is_6", r_data.size() > 0 ? r_data[0] : -1, 6);

    // Negative weights clamp to zero.
    for (int k = 0; k < 8; k++) wts[k] = -8;
    run("wneg", -1, 1'b0, 1'b0);
    chk("wneg/r1_is_0", r_data.size() > 1 ? r_data[1] : -1, 0);

    // Hold mid-neuron.
    rand_data();
    load();
    run("hold", 3, 1'b0, 1'b0);

    // Busy-time writes/start ignored, spurious vld in STREAM ignored.
    rand_data();
    load();
    run("poke", -1, 1'b1, 1'b1);
    run("poke_rerun", -1, 1'b0, 1'b0);

    // Spurious neuron valid while idle.
    clr();
    spur = 1'b1;
    tick();
    spur = 1'b0;
    repeat (3) tick();
    chk("idle_spur/res", r_idx.size(), 0);

    // Abort in WAIT_RES.
    rand_data();
    load();
    clr();
    start = 1'b1;
    s = cyc;
    tick();
    start = 1'b0;
    while (cyc < s + 5) tick();
    rst = 1'b1;
    tick();
    idle_outs("abort");
    rst = 1'b0;
    repeat (4) tick();
    chk("abort/no_res", r_idx.size(), 0);
    chk("abort/no_done", done_cnt, 0);
    run("after_abort", -1, 1'b0, 1'b0);

    // Random runs with random hold windows.
    for (int r = 0; r < 4; r++) begin
      rand_data();
      load();
      run("rand", (r % 2 == 0) ? -1 : int'($urandom_range(2, 8)), 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
